// File: rtl/wb_xbar_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_xbar_pkg
// Purpose  : Shared types, default address map and width helper for the
//            single-master Wishbone interconnect.
// Revision : 1.0 - initial release
// ============================================================================
package wb_xbar_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } xbar_state_e;

    localparam logic [31:0] MEM_START     = 32'h0000_0000;
    localparam logic [31:0] MEM_END       = 32'h000f_ffff;
    localparam logic [31:0] UART_START    = 32'h0010_0000;
    localparam logic [31:0] UART_END      = 32'h0010_0000;
    localparam logic [31:0] DISPLAY_START = 32'h0100_0000;
    localparam logic [31:0] DISPLAY_END   = 32'h0100_0000;
    localparam logic [31:0] UART_RX_START = 32'h1000_0000;
    localparam logic [31:0] UART_RX_END   = 32'h1000_0004;

    // Never returns less than 1 so that single-entry cases still get a real vector.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_xbar_decode.sv
`default_nettype none
// ============================================================================
// Module   : wb_xbar_decode
// Purpose  : Combinational priority address decoder; lowest slave index
//            wins where ranges overlap.
// Revision : 1.0 - initial release
// ============================================================================
module wb_xbar_decode
    import wb_xbar_pkg::*;
#(
    parameter int                          N_SLAVES  = 4,
    parameter int                          ADR_W     = 32,
    parameter logic [N_SLAVES*ADR_W-1:0]   SLV_START = '0,
    parameter logic [N_SLAVES*ADR_W-1:0]   SLV_END   = '0,
    parameter int                          IDX_W     = clog2(N_SLAVES)
) (
    input  logic [ADR_W-1:0] i_adr,
    output logic             o_hit,
    output logic [IDX_W-1:0] o_index,
    output logic             o_miss
);

    logic [N_SLAVES-1:0] w_in_range;

    // Offset-from-start compare keeps each range test a single unsigned compare.
    for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_range
        localparam logic [ADR_W-1:0] c_START = SLV_START[gi*ADR_W +: ADR_W];
        localparam logic [ADR_W-1:0] c_SPAN  = SLV_END[gi*ADR_W +: ADR_W] - c_START;
        assign w_in_range[gi] = ((i_adr - c_START) <= c_SPAN);
    end

    always_comb begin
        o_index = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if (w_in_range[i]) begin
                o_index = IDX_W'(i);
            end
        end
    end

    assign o_hit  = |w_in_range;
    assign o_miss = ~o_hit;

endmodule
`default_nettype wire

// File: rtl/wb_xbar_n.sv
`default_nettype none
// ============================================================================
// Module   : wb_xbar_n
// Purpose  : Single-master, N-slave Wishbone classic interconnect with a
//            registered grant, per-transaction timeout and fault capture.
// Revision : 1.0 - initial release
// ============================================================================
module wb_xbar_n
    import wb_xbar_pkg::*;
#(
    parameter int                        N_SLAVES       = 4,
    parameter int                        ADR_W          = 32,
    parameter int                        DAT_W          = 32,
    parameter logic [N_SLAVES*ADR_W-1:0] SLV_START      = {UART_RX_START, DISPLAY_START,
                                                           UART_START, MEM_START},
    parameter logic [N_SLAVES*ADR_W-1:0] SLV_END        = {UART_RX_END, DISPLAY_END,
                                                           UART_END, MEM_END},
    parameter int                        TIMEOUT_CYCLES = 255,
    parameter bit                        UNMAPPED_ERR   = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADR_W-1:0]          cpu_adr,
    input  logic [DAT_W-1:0]          cpu_dat_o,
    input  logic                      cpu_we,
    input  logic                      cpu_cyc,
    input  logic                      cpu_stb,
    output logic [DAT_W-1:0]          cpu_dat_i,
    output logic                      cpu_ack,
    output logic                      cpu_err,
    output logic [N_SLAVES*ADR_W-1:0] slv_adr,
    output logic [N_SLAVES*DAT_W-1:0] slv_dat_o,
    output logic [N_SLAVES-1:0]       slv_we,
    output logic [N_SLAVES-1:0]       slv_cyc,
    output logic [N_SLAVES-1:0]       slv_stb,
    input  logic [N_SLAVES*DAT_W-1:0] slv_dat_i,
    input  logic [N_SLAVES-1:0]       slv_ack,
    output logic                      err_valid,
    output logic [ADR_W-1:0]          err_adr,
    output logic                      err_timeout
);

    localparam int                 c_IDX_W   = clog2(N_SLAVES);
    localparam int                 c_CNT_W   = clog2(TIMEOUT_CYCLES + 1);
    localparam bit                 c_TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    xbar_state_e          state_q, state_d;
    logic [c_IDX_W-1:0]   grant_q, grant_d;
    logic [c_CNT_W-1:0]   cnt_q, cnt_d;
    logic                 cause_q, cause_d;
    logic                 err_valid_q, err_valid_d;
    logic [ADR_W-1:0]     err_adr_q, err_adr_d;
    logic                 err_timeout_q, err_timeout_d;

    logic                 w_hit;
    logic                 w_miss;
    logic [c_IDX_W-1:0]   w_index;
    logic [DAT_W-1:0]     w_slv_dat [N_SLAVES];

    wb_xbar_decode #(
        .N_SLAVES  (N_SLAVES),
        .ADR_W     (ADR_W),
        .SLV_START (SLV_START),
        .SLV_END   (SLV_END),
        .IDX_W     (c_IDX_W)
    ) u_decode (
        .i_adr     (cpu_adr),
        .o_hit     (w_hit),
        .o_index   (w_index),
        .o_miss    (w_miss)
    );

    for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_unpack
        assign w_slv_dat[gi] = slv_dat_i[gi*DAT_W +: DAT_W];
    end

    assign slv_adr   = {N_SLAVES{cpu_adr}};
    assign slv_dat_o = {N_SLAVES{cpu_dat_o}};
    assign slv_we    = {N_SLAVES{cpu_we}};
    assign slv_cyc   = {N_SLAVES{cpu_cyc}};

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        cnt_d         = '0;
        cause_d       = cause_q;
        err_valid_d   = err_valid_q;
        err_adr_d     = err_adr_q;
        err_timeout_d = err_timeout_q;
        slv_stb       = '0;
        cpu_ack       = 1'b0;
        cpu_err       = 1'b0;
        cpu_dat_i     = '0;

        case (state_q)
            ST_IDLE: begin
                if (cpu_cyc && cpu_stb) begin
                    if (w_hit) begin
                        grant_d = w_index;
                        state_d = ST_BUSY;
                    end
                    if (w_miss) begin
                        cause_d = 1'b0;
                        state_d = ST_RESP;
                    end
                end
            end

            ST_BUSY: begin
                cpu_dat_i = w_slv_dat[grant_q];
                if (!cpu_cyc) begin
                    state_d = ST_IDLE;
                end else begin
                    slv_stb[grant_q] = cpu_stb;
                    cpu_ack          = slv_ack[grant_q];
                    // A late ACK on the final allowed cycle still completes normally.
                    if (slv_ack[grant_q]) begin
                        state_d = ST_IDLE;
                    end else if (c_TO_EN && (cnt_q == c_TO_LAST)) begin
                        cause_d = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        cnt_d = cnt_q + c_CNT_W'(1);
                    end
                end
            end

            ST_RESP: begin
                if (cpu_cyc) begin
                    cpu_ack       = ~UNMAPPED_ERR;
                    cpu_err       = UNMAPPED_ERR;
                    err_valid_d   = 1'b1;
                    err_adr_d     = cpu_adr;
                    err_timeout_d = cause_q;
                end
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            cnt_q         <= '0;
            cause_q       <= 1'b0;
            err_valid_q   <= 1'b0;
            err_adr_q     <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            cnt_q         <= cnt_d;
            cause_q       <= cause_d;
            err_valid_q   <= err_valid_d;
            err_adr_q     <= err_adr_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign err_valid   = err_valid_q;
    assign err_adr     = err_adr_q;
    assign err_timeout = err_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_xbar_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_xbar_n
// Purpose  : Self-checking bench for wb_xbar_n: two instances (ACK and ERR
//            fault responses) share stimulus and a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_xbar_n;

    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  adr;
    logic [31:0]  dat_o;
    logic         we;
    logic         cyc;
    logic         stb;
    logic [127:0] sdat_i;
    logic [3:0]   sack;

    logic [31:0]  o_dat  [2];
    logic         o_ack  [2];
    logic         o_err  [2];
    logic [127:0] o_sadr [2];
    logic [127:0] o_sdat [2];
    logic [3:0]   o_swe  [2];
    logic [3:0]   o_scyc [2];
    logic [3:0]   o_sstb [2];
    logic         o_ev   [2];
    logic [31:0]  o_eadr [2];
    logic         o_eto  [2];

    int total = 0;
    int bad   = 0;

    // Transaction-level model: which slave owns the bus, how long it has
    // waited, whether a fault response is due, and the captured fault.
    int          m_slave   = -1;
    int          m_wait    = 0;
    bit          m_resp    = 1'b0;
    bit          m_resp_to = 1'b0;
    bit          e_valid   = 1'b0;
    logic [31:0] e_adr     = '0;
    bit          e_to      = 1'b0;

    initial forever #5 clk = ~clk;

    wb_xbar_n #(.TIMEOUT_CYCLES(TO), .UNMAPPED_ERR(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .cpu_adr(adr), .cpu_dat_o(dat_o), .cpu_we(we),
        .cpu_cyc(cyc), .cpu_stb(stb), .cpu_dat_i(o_dat[0]), .cpu_ack(o_ack[0]),
        .cpu_err(o_err[0]), .slv_adr(o_sadr[0]), .slv_dat_o(o_sdat[0]),
        .slv_we(o_swe[0]), .slv_cyc(o_scyc[0]), .slv_stb(o_sstb[0]),
        .slv_dat_i(sdat_i), .slv_ack(sack), .err_valid(o_ev[0]),
        .err_adr(o_eadr[0]), .err_timeout(o_eto[0])
    );

    wb_xbar_n #(.TIMEOUT_CYCLES(TO), .UNMAPPED_ERR(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .cpu_adr(adr), .cpu_dat_o(dat_o), .cpu_we(we),
        .cpu_cyc(cyc), .cpu_stb(stb), .cpu_dat_i(o_dat[1]), .cpu_ack(o_ack[1]),
        .cpu_err(o_err[1]), .slv_adr(o_sadr[1]), .slv_dat_o(o_sdat[1]),
        .slv_we(o_swe[1]), .slv_cyc(o_scyc[1]), .slv_stb(o_sstb[1]),
        .slv_dat_i(sdat_i), .slv_ack(sack), .err_valid(o_ev[1]),
        .err_adr(o_eadr[1]), .err_timeout(o_eto[1])
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Default memory map of the CPU bus.
    function automatic int slave_of(input logic [31:0] a);
        if (a <= 32'h000f_ffff) return 0;
        if (a == 32'h0010_0000) return 1;
        if (a == 32'h0100_0000) return 2;
        if (a >= 32'h1000_0000 && a <= 32'h1000_0004) return 3;
        return -1;
    endfunction

    task automatic model_step();
        int s;
        if (!rst) begin
            m_slave = -1; m_wait = 0; m_resp = 1'b0; m_resp_to = 1'b0;
            e_valid = 1'b0; e_adr = '0; e_to = 1'b0;
        end else if (m_slave >= 0) begin
            if (!cyc || sack[m_slave]) begin
                m_slave = -1;
                m_wait  = 0;
            end else if (m_wait + 1 == TO) begin
                m_slave   = -1;
                m_wait    = 0;
                m_resp    = 1'b1;
                m_resp_to = 1'b1;
            end else begin
                m_wait++;
            end
        end else if (m_resp) begin
            if (cyc) begin
                e_valid = 1'b1;
                e_adr   = adr;
                e_to    = m_resp_to;
            end
            m_resp = 1'b0;
        end else if (cyc && stb) begin
            s = slave_of(adr);
            if (s >= 0) begin
                m_slave = s;
                m_wait  = 0;
            end else begin
                m_resp    = 1'b1;
                m_resp_to = 1'b0;
            end
        end
    endtask

    task automatic compare();
        logic [3:0]  x_stb;
        logic        x_ack;
        logic        x_err;
        logic [31:0] x_dat;
        for (int d = 0; d < 2; d++) begin
            x_stb = '0; x_ack = 1'b0; x_err = 1'b0; x_dat = '0;
            if (m_slave >= 0) begin
                x_dat = sdat_i[m_slave*32 +: 32];
                if (cyc) begin
                    x_stb[m_slave] = stb;
                    x_ack          = sack[m_slave];
                end
            end else if (m_resp && cyc) begin
                if (d == 0) x_ack = 1'b1;
                else        x_err = 1'b1;
            end
            chk($sformatf("dut%0d_stb", d),   o_sstb[d], x_stb);
            chk($sformatf("dut%0d_ack", d),   o_ack[d],  x_ack);
            chk($sformatf("dut%0d_err", d),   o_err[d],  x_err);
            chk($sformatf("dut%0d_dat", d),   o_dat[d],  x_dat);
            chk($sformatf("dut%0d_ev", d),    o_ev[d],   e_valid);
            chk($sformatf("dut%0d_eadr", d),  o_eadr[d], e_adr);
            chk($sformatf("dut%0d_eto", d),   o_eto[d],  e_to);
            chk($sformatf("dut%0d_bcast", d),
                {o_sadr[d], o_sdat[d], o_swe[d], o_scyc[d]},
                {{4{adr}}, {4{dat_o}}, {4{we}}, {4{cyc}}});
            chk($sformatf("dut%0d_onehot", d), ($countones(o_sstb[d]) <= 1), 1'b1);
        end
    endtask

    initial begin : p_model
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            compare();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic release_bus();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sack = '0;
    endtask

    task automatic request(input logic [31:0] a, input logic w, input logic [31:0] d);
        adr = a; we = w; dat_o = d; cyc = 1'b1; stb = 1'b1;
    endtask

    function automatic logic [31:0] pick_adr();
        case ($urandom_range(0, 14))
            0:  return 32'h0000_0000;
            1:  return 32'h0000_0010;
            2:  return 32'h000f_ffff;
            3:  return 32'h0010_0000;
            4:  return 32'h0010_0001;
            5:  return 32'h00ff_ffff;
            6:  return 32'h0100_0000;
            7:  return 32'h0100_0001;
            8:  return 32'h1000_0000;
            9:  return 32'h1000_0004;
            10: return 32'h1000_0005;
            11: return 32'h2000_0000;
            12: return 32'hffff_ffff;
            13: return 32'h0fff_ffff;
            default: return $urandom();
        endcase
    endfunction

    initial begin : p_main
        rst = 1'b0; adr = '0; dat_o = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
        sdat_i = '0; sack = '0;
        repeat (3) step();
        rst = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_outputs", {o_sstb[d], o_ack[d], o_err[d], o_dat[d]}, '0);
            chk("reset_fault", {o_ev[d], o_eadr[d], o_eto[d]}, '0);
        end
        step();

        // Read from slave 0, ACK two cycles after its strobe.
        request(32'h0000_0010, 1'b0, '0);
        @(negedge clk); chk("rd_req_stb", o_sstb[0], 4'b0000);
        step();
        @(negedge clk); chk("rd_stb0", o_sstb[0], 4'b0001);
        step();
        step();
        sack = 4'b0001; sdat_i[31:0] = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("rd_ack", {o_ack[0], o_ack[1], o_err[1]}, 3'b110);
        chk("rd_data", o_dat[0], 32'hDEAD_BEEF);
        step(); release_bus();
        @(negedge clk); chk("rd_idle", {o_sstb[0], o_ack[0]}, 5'b0);
        step();

        // Write to slave 1.
        request(32'h0010_0000, 1'b1, 32'h0000_0041);
        step(); sack = 4'b0010;
        @(negedge clk);
        chk("wr_stb1", o_sstb[1], 4'b0010);
        chk("wr_data", o_sdat[1][63:32], 32'h0000_0041);
        chk("wr_we", o_swe[1], 4'b1111);
        chk("wr_ack", o_ack[0], 1'b1);
        step(); release_bus(); step();

        // ACK on the very cycle the timeout would fire.
        request(32'h0100_0000, 1'b0, '0);
        step();
        repeat (TO - 1) step();
        sack = 4'b0100; sdat_i[95:64] = 32'h0000_1234;
        @(negedge clk);
        chk("race_ack", {o_ack[0], o_ack[1], o_err[0], o_err[1]}, 4'b1100);
        chk("race_dat", o_dat[1], 32'h0000_1234);
        step(); release_bus();
        @(negedge clk); chk("race_noerr", {o_ev[0], o_ev[1], o_sstb[0]}, 6'b0);
        step();

        // Abort by dropping cyc while BUSY.
        request(32'h0000_0020, 1'b0, '0);
        step();
        @(negedge clk); chk("abort_stb", o_sstb[0], 4'b0001);
        step(); release_bus();
        @(negedge clk); chk("abort_resp", {o_ack[0], o_err[0], o_ack[1], o_err[1]}, 4'b0);
        step();
        @(negedge clk); chk("abort_idle", o_sstb[0], 4'b0000);
        step();

        // Unmapped access.
        request(32'h2000_0000, 1'b0, '0);
        @(negedge clk); chk("unm_req", {o_sstb[0], o_ack[0], o_err[1]}, 6'b0);
        step();
        @(negedge clk);
        chk("unm_resp0", {o_ack[0], o_err[0]}, 2'b10);
        chk("unm_resp1", {o_ack[1], o_err[1]}, 2'b01);
        chk("unm_dat", o_dat[0], 32'h0);
        step(); release_bus();
        @(negedge clk);
        chk("unm_fault", {o_ev[1], o_eadr[1], o_eto[1]}, {1'b1, 32'h2000_0000, 1'b0});
        step();

        // Slave that never ACKs.
        request(32'h0100_0000, 1'b0, '0);
        step();
        for (int k = 0; k < TO; k++) begin
            @(negedge clk); chk("to_stb2", o_sstb[1], 4'b0100);
            step();
        end
        @(negedge clk);
        chk("to_drop", o_sstb[1], 4'b0000);
        chk("to_resp", {o_err[1], o_ack[1], o_ack[0]}, 3'b101);
        step(); release_bus();
        @(negedge clk);
        chk("to_fault", {o_ev[1], o_eadr[1], o_eto[1]}, {1'b1, 32'h0100_0000, 1'b1});
        step();

        // Reset while BUSY.
        request(32'h0010_0000, 1'b0, '0);
        step();
        @(negedge clk); chk("rstb_stb", o_sstb[0], 4'b0010);
        step(); rst = 1'b0;
        step(); rst = 1'b1; release_bus();
        @(negedge clk);
        chk("rstb_out", {o_sstb[0], o_ack[0], o_err[1], o_dat[0]}, '0);
        chk("rstb_fault", {o_ev[0], o_eadr[0], o_eto[0]}, '0);
        step();

        // Back-to-back accesses to slaves 0 and 3.
        request(32'h0000_0004, 1'b0, '0);
        step(); sack = 4'b0001; sdat_i[31:0] = 32'h0000_A5A5;
        @(negedge clk); chk("b2b_s0", {o_sstb[0], o_ack[0]}, 5'b0001_1);
        step(); sack = '0; adr = 32'h1000_0004;
        @(negedge clk); chk("b2b_gap", o_sstb[0], 4'b0000);
        step(); sack = 4'b1000; sdat_i[127:96] = 32'h0000_5A5A;
        @(negedge clk);
        chk("b2b_s3", {o_sstb[0], o_ack[0]}, 5'b1000_1);
        chk("b2b_dat", o_dat[0], 32'h0000_5A5A);
        step(); release_bus(); step();

        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 5) == 0) adr = pick_adr();
            cyc   = ($urandom_range(0, 19) != 0);
            stb   = ($urandom_range(0, 7) != 0);
            we    = 1'($urandom_range(0, 1));
            dat_o = $urandom();
            for (int s = 0; s < 4; s++) sack[s] = ($urandom_range(0, 5) == 0);
            sdat_i = {$urandom(), $urandom(), $urandom(), $urandom()};
            step();
        end
        rst = 1'b1;
        release_bus();
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_xbar_n.md
Name: wb_xbar_n

Overview:
- Parametrised single-master, N-slave Wishbone classic interconnect; successor to the fixed 4-slave address decoder between the CPU bus and the memory/UART/display/UART-RX peripherals.
- Adds:
  - a registered grant that is held for the whole cycle;
  - a per-transaction slave timeout;
  - a selectable response for unmapped addresses (ACK or ERR);
  - sticky capture of the last faulting address.

Parameters:
- N_SLAVES, 4, number of slave ports (1..16).
- ADR_W, 32, address width.
- DAT_W, 32, data width.
- SLV_START, {32'h10000000, 32'h01000000, 32'h00100000, 32'h00000000}, packed N_SLAVES*ADR_W; inclusive start address per slave; slave 0 in the LSBs.
- SLV_END, {32'h10000004, 32'h01000000, 32'h00100000, 32'h000fffff}, packed N_SLAVES*ADR_W; inclusive end address per slave.
- TIMEOUT_CYCLES, 255, maximum BUSY cycles without a slave ACK; 0 disables the timeout.
- UNMAPPED_ERR, 0, response for unmapped addresses and timeouts: 0 = pulse cpu_ack with data 0; 1 = pulse cpu_err.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- cpu_adr  in  ADR_W  master address.
- cpu_dat_o  in  DAT_W  master write data.
- cpu_we  in  1  master write enable.
- cpu_cyc  in  1  master cycle.
- cpu_stb  in  1  master strobe.
- cpu_dat_i  out  DAT_W  read data to master.
- cpu_ack  out  1  acknowledge to master.
- cpu_err  out  1  error to master.
- slv_adr  out  N_SLAVES*ADR_W  address, broadcast to every slave.
- slv_dat_o  out  N_SLAVES*DAT_W  write data, broadcast.
- slv_we  out  N_SLAVES  write enable, broadcast.
- slv_cyc  out  N_SLAVES  cycle, broadcast.
- slv_stb  out  N_SLAVES  strobe; at most one bit high.
- slv_dat_i  in  N_SLAVES*DAT_W  read data from each slave.
- slv_ack  in  N_SLAVES  acknowledge from each slave.
- err_valid  out  1  sticky: an unmapped access or timeout has occurred.
- err_adr  out  ADR_W  address of the most recent fault.
- err_timeout  out  1  1 = most recent fault was a timeout; 0 = unmapped.

Behaviour:
- Reset (rst==0 at a rising edge):
  - state=IDLE, grant=0, timeout counter=0.
  - err_valid=0, err_adr=0, err_timeout=0.
  - All slv_stb=0, cpu_ack=0, cpu_err=0, cpu_dat_i=0.
  - Reset mid-transaction aborts the transaction with no response.
- Pass-through: slv_adr, slv_dat_o, slv_we and slv_cyc are combinational copies of the cpu signals on every port.
- Decode (combinational):
  - hit[i] = SLV_START[i] <= cpu_adr <= SLV_END[i].
  - Lowest index wins on overlap.
  - miss = no hit.
- State IDLE:
  - All slv_stb=0.
  - On cpu_cyc & cpu_stb & hit: latch grant=index; go to BUSY.
  - On cpu_cyc & cpu_stb & miss: go to RESP.
- State BUSY:
  - slv_stb[grant] = cpu_stb & cpu_cyc.
  - cpu_dat_i = slv_dat_i[grant] (combinational).
  - cpu_ack = slv_ack[grant] (combinational).
  - Counter increments each cycle.
  - On slv_ack[grant]: return to IDLE next cycle; counter cleared.
  - Latency: request-to-slave strobe is 1 cycle; each transaction is followed by 1 IDLE cycle.
  - Address changes while BUSY do not move the grant.
- Timeout:
  - In BUSY, if TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES without ACK: go to RESP with err_timeout=1.
  - slv_stb drops in the RESP cycle.
  - A slave ACK arriving in the same cycle as the timeout takes priority: normal completion, no fault.
- State RESP:
  - Lasts exactly one cycle.
  - If UNMAPPED_ERR=0: cpu_ack=1 and cpu_dat_i=0. Else: cpu_err=1.
  - err_valid<=1; err_adr<=cpu_adr; err_timeout set per cause.
  - Then go to IDLE.
- Abort: cpu_cyc==0 in BUSY or RESP returns to IDLE next cycle with no cpu_ack or cpu_err; the counter clears.
- Stray inputs: slv_ack from non-granted slaves is ignored. cpu_ack and cpu_err are never high together.
- Fault capture: err_valid is sticky until reset. err_adr and err_timeout update on every fault.

Decomposition:
- Package wb_xbar_pkg:
  - state enum {IDLE, BUSY, RESP};
  - default address-map constants (MEM_START/END, UART_START/END, DISPLAY_START/END, UART_RX_START/END);
  - function clog2 for the grant and counter widths.
- Sub-module wb_xbar_decode: combinational priority address decoder. Outputs hit (1), index (clog2 N_SLAVES) and miss (1). Instantiated once.

Test Plan:
- Read 32'h00000010 with slave 0 ACKing 2 cycles after slv_stb[0] and returning 32'hDEADBEEF -> slv_stb=4'b0001 from cycle 1; cpu_ack for one cycle with cpu_dat_i=32'hDEADBEEF; IDLE the next cycle.
- Write 32'h00000041 to 32'h00100000 -> only slv_stb[1] high; slv_dat_o carries 32'h41 with we=1; cpu_ack follows slv_ack[1].
- Access 32'h20000000 with UNMAPPED_ERR=0 -> no slv_stb; cpu_ack 1 cycle after the request with cpu_dat_i=0; err_valid=1, err_adr=32'h20000000, err_timeout=0. Rerun with UNMAPPED_ERR=1 -> cpu_err instead of cpu_ack.
- Access 32'h01000000 with the slave never ACKing and TIMEOUT_CYCLES=8 -> slv_stb[2] high for 8 cycles, then dropped; cpu_err (UNMAPPED_ERR=1) pulse; err_timeout=1.
- Slave ACK in the same cycle the timeout fires -> normal cpu_ack, err_valid stays 0. Separately, cpu_cyc dropped mid-BUSY -> IDLE next cycle, no cpu_ack or cpu_err.
- Reset asserted (rst=0) for 1 cycle while BUSY -> all outputs 0 the next cycle. Then issue back-to-back accesses to slaves 0 and 3 -> each completes; grant switches; at most one slv_stb bit high at any time.
